// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Turns a compact instruction request (op, rd, rs1, rs2, imm) into an RV32I
//   machine word. Each legal word is tagged with a running byte address and
//   queued in a small circular FIFO. Illegal requests are still accepted, but
//   they only raise a sticky error flag.
//
// Parameters
//   BASE_ADDR   byte address tagged on the first emitted word
//   FIFO_DEPTH  output buffer entries (power of two, >= 2)
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready = buffer not full)
//   in_op                  0=ADD 1=AND 2=SLL 3=ORI 4=LB 5=SB 6=BNE 7=illegal
//   in_rd/in_rs1/in_rs2    register fields
//   in_imm                 13-bit signed immediate / branch byte offset
//   out_valid / out_ready  output handshake (out_valid = buffer not empty)
//   out_instr, out_addr    encoded word and its address at buffer head
//   err                    sticky flag, set by any rejected request
//   word_count             saturating count of output handshakes
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [12:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [15:0] word_count
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_ORI = 3'd3;
    localparam logic [2:0] OP_LB  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_BNE = 3'd6;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    // ------------------------------------------------------------------
    // Encoder: purely combinational, evaluated for whatever is on the input
    // ------------------------------------------------------------------
    logic [31:0] enc_instr;
    logic        enc_illegal;
    logic        imm_fits12;

    // A 12-bit immediate field can only represent in_imm if the top two bits
    // agree (bit 12 would be lost otherwise).
    assign imm_fits12 = (in_imm[12] == in_imm[11]);

    always_comb begin
        enc_instr   = '0;
        enc_illegal = 1'b0;
        unique case (in_op)
            OP_ADD: enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            OP_AND: enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
            OP_SLL: enc_instr = {7'b0000000, in_rs2, in_rs1, 3'b001, in_rd, OPC_R};
            OP_ORI: begin
                enc_instr   = {in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_I};
                enc_illegal = ~imm_fits12;
            end
            OP_LB: begin
                enc_instr   = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_LOAD};
                enc_illegal = ~imm_fits12;
            end
            OP_SB: begin
                enc_instr   = {in_imm[11:5], in_rs2, in_rs1, 3'b000, in_imm[4:0], OPC_S};
                enc_illegal = ~imm_fits12;
            end
            OP_BNE: begin
                // Branch offsets are even; bit 0 has no place in the B format.
                enc_instr   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                               in_imm[4:1], in_imm[11], OPC_B};
                enc_illegal = in_imm[0];
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    entry_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [31:0]     addr_q,   addr_d;
    logic            err_q,    err_d;
    logic [15:0]     wcnt_q,   wcnt_d;

    logic accept, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count_q < CW'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);

    assign accept = in_valid & in_ready;
    assign push   = accept & ~enc_illegal;
    assign pop    = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        wcnt_d   = wcnt_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            addr_d   = addr_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
        end
        // Push and pop in the same cycle leave occupancy alone.
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (accept && enc_illegal) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Storage carries no reset; stale contents are never visible because the
    // head is only exposed while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= '{instr: enc_instr, addr: addr_q};
        end
    end

    assign out_instr  = out_valid ? mem_q[rd_ptr_q].instr : 32'h0;
    assign out_addr   = out_valid ? mem_q[rd_ptr_q].addr  : 32'h0;
    assign err        = err_q;
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_addr;
    logic        err;
    logic [15:0] word_count;

    // second instance for address wrap
    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [31:0] b_out_instr, b_out_addr;
    logic [15:0] b_word_count;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err),
        .word_count(word_count)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_op(3'd0), .in_rd(5'd1), .in_rs1(5'd2), .in_rs2(5'd3),
        .in_imm(13'd0), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_instr(b_out_instr), .out_addr(b_out_addr), .err(b_err),
        .word_count(b_word_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [63:0] mq[$];
    logic [31:0] m_addr;
    logic        m_err;
    int          m_wc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoding built field by field with shifts and masks.
    function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
        int unsigned w;
        int unsigned u;
        u = imm & 32'h1FFF;
        w = 0;
        case (op)
            0: w = 'h33 + (rd << 7) + (0 << 12) + (rs1 << 15) + (rs2 << 20);
            1: w = 'h33 + (rd << 7) + (7 << 12) + (rs1 << 15) + (rs2 << 20);
            2: w = 'h33 + (rd << 7) + (1 << 12) + (rs1 << 15) + (rs2 << 20);
            3: w = 'h13 + (rd << 7) + (6 << 12) + (rs1 << 15) + ((u & 'hFFF) << 20);
            4: w = 'h03 + (rd << 7) + (0 << 12) + (rs1 << 15) + ((u & 'hFFF) << 20);
            5: w = 'h23 + ((u & 'h1F) << 7) + (rs1 << 15) + (rs2 << 20)
                   + (((u >> 5) & 'h7F) << 25);
            6: w = 'h63 + (((u >> 11) & 1) << 7) + (((u >> 1) & 'hF) << 8) + (1 << 12)
                   + (rs1 << 15) + (rs2 << 20) + (((u >> 5) & 'h3F) << 25)
                   + (((u >> 12) & 1) << 31);
            default: w = 0;
        endcase
        return w;
    endfunction

    function automatic bit ref_illegal(input int op, input logic [12:0] imm);
        int s;
        s = $signed(imm);
        if (op == 7) return 1'b1;
        if (op == 6) return imm[0];
        if (op >= 3 && op <= 5) return (s < -2048) || (s > 2047);
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr = 32'h0;
        m_err  = 1'b0;
        m_wc   = 0;
    endtask

    task automatic drive(input logic v, input int op, input int rd, input int rs1,
                         input int rs2, input int imm);
        in_valid = v;
        in_op    = 3'(op);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = 13'(imm);
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit acc, deq;
        @(negedge clk);
        chk("in_ready",   {31'd0, in_ready},  {31'd0, mq.size() < DEPTH});
        chk("out_valid",  {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("out_instr",  out_instr, (mq.size() > 0) ? mq[0][63:32] : 32'h0);
        chk("out_addr",   out_addr,  (mq.size() > 0) ? mq[0][31:0]  : 32'h0);
        chk("err",        {31'd0, err}, {31'd0, m_err});
        chk("word_count", {16'd0, word_count}, 32'(m_wc));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            deq = out_ready && (mq.size() > 0);
            if (deq) begin
                void'(mq.pop_front());
                if (m_wc < 65535) m_wc++;
            end
            if (acc) begin
                if (ref_illegal(int'(in_op), in_imm)) m_err = 1'b1;
                else begin
                    mq.push_back({ref_enc(int'(in_op), int'(in_rd), int'(in_rs1),
                                          int'(in_rs2), int'($signed(in_imm))), m_addr});
                    m_addr = m_addr + 32'd4;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp35 [3];
        exp35[0] = 32'hFFF2E293;
        exp35[1] = 32'hFE209CE3;
        exp35[2] = 32'h00310223;

        rst = 1'b1; out_ready = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0);
        b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();                       // checks reset values
        rst = 1'b0;

        // single ADD, latency 1
        out_ready = 1'b1;
        drive(1'b1, 0, 1, 2, 3, 0);
        step();
        in_valid = 1'b0;
        chk("add_instr", out_instr, 32'h003100B3);
        chk("add_addr",  out_addr,  32'h0);
        step();
        chk("add_wc", {16'd0, word_count}, 32'd1);

        // ORI / BNE / SB encodings and addresses
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 3, 5, 5, 0, -1);  step();
        drive(1'b1, 6, 0, 1, 2, -8);  step();
        drive(1'b1, 5, 0, 2, 3, 4);   step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("seq_instr", out_instr, exp35[k]);
            chk("seq_addr",  out_addr,  32'(4 * k));
            step();
        end

        // backpressure: full FIFO then drain
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i % 3, i + 1, i + 2, i + 3, 0);
            step();
        end
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 1, 5, 6, 7, 0);
        out_ready = 1'b1;
        step();
        chk("slot_free", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        repeat (6) step();
        chk("drain_wc", {16'd0, word_count}, 32'd5);

        // rejections
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 7, 1, 1, 1, 0);       step();
        drive(1'b1, 6, 0, 1, 2, 3);       step();
        drive(1'b1, 4, 1, 2, 0, 'h800);   step();
        in_valid = 1'b0;
        step();
        chk("rej_err",   {31'd0, err},       32'd1);
        chk("rej_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 0, 1, 2, 3, 0);       step();
        in_valid = 1'b0;
        chk("rej_addr", out_addr, 32'h0);
        step();

        // mid-stream reset discards buffered words
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, i, i, i, 0);
            step();
        end
        do_reset();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 2, 9, 8, 7, 0);       step();
        in_valid = 1'b0;
        chk("rst_addr", out_addr, 32'h0);
        chk("rst_wc",   {16'd0, word_count}, 32'd0);
        out_ready = 1'b1;
        step();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int op, imm;
            rst = ($urandom_range(63) == 0);
            op  = $urandom_range(7);
            imm = ($urandom_range(1) == 1) ? int'($urandom) : $urandom_range(4095) - 2048;
            drive($urandom_range(9) < 7, op, $urandom_range(31), $urandom_range(31),
                  $urandom_range(31), imm);
            out_ready = $urandom_range(9) < 6;
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;

        // address wrap on the high-base instance
        b_rst = 1'b0;
        b_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("wrap_addr0", b_out_addr, 32'hFFFF_FFFC);
        chk("wrap_instr", b_out_instr, 32'h003100B3);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_valid", {31'd0, b_out_valid}, 32'd1);
        chk("wrap_addr1", b_out_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address tagged on the first emitted word.
REQ-002 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  request accepted this cycle if in_valid.
REQ-007 in_op  in  3  0=ADD, 1=AND, 2=SLL, 3=ORI, 4=LB, 5=SB, 6=BNE, 7=illegal.
REQ-008 in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-009 in_imm  in  13  signed two's-complement immediate or branch byte offset.
REQ-010 out_valid  out  1  buffered word available.
REQ-011 out_ready  in  1  consumer takes the word this cycle if out_valid.
REQ-012 out_instr  out  32  encoded RV32I word at buffer head.
REQ-013 out_addr  out  32  byte address tagged on out_instr.
REQ-014 err  out  1  sticky rejected-request flag.
REQ-015 word_count  out  16  number of completed output handshakes.

Function
REQ-016 Accept = in_valid & in_ready; in_ready SHALL be 1 exactly when FIFO occupancy < FIFO_DEPTH, with no same-cycle bypass when full.
REQ-017 Dequeue = out_valid & out_ready; out_valid SHALL be 1 exactly when occupancy > 0.
REQ-018 An accepted legal request SHALL be encoded and written to the FIFO on the accepting edge, so out_valid rises on the next cycle (latency 1) when the FIFO was empty.
REQ-019 Encoding (opcode, funct3, funct7):
- ADD: 0110011, 000, 0000000.
- AND: 0110011, 111, 0000000.
- SLL: 0110011, 001, 0000000.
- ORI: 0010011, 110, imm[11:0] in bits 31:20.
- LB: 0000011, 000, imm[11:0] in bits 31:20.
- SB: 0100011, 000, imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
- BNE: 1100011, 001; imm[12] in bit 31, imm[10:5] in bits 30:25, imm[4:1] in bits 11:8, imm[11] in bit 7.
REQ-020 Unused fields SHALL be zero-driven: rs2 for ORI/LB, rd for SB/BNE, in_imm for R-type.
REQ-021 Rejection: in_op=7; or BNE with in_imm[0]=1; or ORI/LB/SB with in_imm[12]!=in_imm[11].
REQ-022 A rejected request SHALL still be accepted (consumes in_ready), set err, and write no FIFO entry.
REQ-023 A rejected request SHALL NOT advance the address counter.
REQ-024 The address counter SHALL start at BASE_ADDR and add 4 per enqueued word, wrapping modulo 2^32.
REQ-025 Each FIFO entry SHALL hold {instr, addr}; the FIFO is a circular buffer with read/write pointers wrapping at FIFO_DEPTH.
REQ-026 Simultaneous accept and dequeue SHALL leave occupancy unchanged and preserve order.
REQ-027 Output SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 word_count SHALL increment per dequeue and saturate at 16'hFFFF.
REQ-029 err SHALL stay 1 until reset.

Reset
REQ-030 rst=1 at an edge SHALL set occupancy 0, pointers 0, address counter BASE_ADDR, err 0, word_count 0.
REQ-031 Outputs after reset: out_valid=0, in_ready=1, out_instr=0, out_addr=0.
REQ-032 rst SHALL override a simultaneous accept or dequeue.
REQ-033 Entries buffered before a mid-stream reset SHALL be discarded, never emitted.

Verification
REQ-034 ADD rd=1 rs1=2 rs2=3, out_ready=1 -> next cycle out_instr=32'h003100B3, out_addr=BASE_ADDR, word_count=1 after the handshake.
REQ-035 ORI rd=5 rs1=5 imm=-1, then BNE rs1=1 rs2=2 imm=-8, then SB rs1=2 rs2=3 imm=4 -> out_instr 32'hFFF2E293, 32'hFE209CE3, 32'h00310223 at addresses +0, +4, +8.
REQ-036 Hold out_ready=0 and offer 5 legal requests -> in_ready=0 after 4 accepts. Then set out_ready=1 -> words drain in order with no duplicates, and the 5th request is accepted on the cycle after the first dequeue frees a slot.
REQ-037 in_op=7, then BNE imm=3, then LB imm=13'h0800 -> err=1, out_valid stays 0, and a following legal ADD is tagged BASE_ADDR.
REQ-038 Pulse rst with 3 words buffered -> out_valid=0 the next cycle, and the next legal word is tagged BASE_ADDR with word_count=0 before its handshake.
REQ-039 With BASE_ADDR=32'hFFFF_FFFC, two legal ADDs -> addresses 32'hFFFF_FFFC then 32'h0000_0000.
